// File: rtl/iref_seq_if.sv
// CPU register bus for the current-reference sequencer.
// Master drives a request strobe with address/data; slave acks one cycle later.
interface iref_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iref_seq.sv
// Current-reference power/charge sequencer with a small CPU register file.
// Latency: register access acked 1 cycle after valid; no backpressure, back-to-back requests acked every cycle.
module iref_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    iref_seq_if.slave  bus,
    output logic       pd,
    output logic [7:0] charge
);
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SETTLE = 3'd1,
        S_RAMP   = 3'd2,
        S_LOCKED = 3'd3,
        S_RAMPDN = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TARGET = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_SETTLE = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

    state_t      state;
    logic        en;
    logic [7:0]  target;
    logic [15:0] step_div;
    logic [15:0] settle;
    logic [15:0] settle_cnt;
    logic [15:0] div_cnt;

    logic              wr_en;
    logic              rd_en;
    logic              busy;
    logic              locked;
    logic              step_due;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    assign wr_en        = bus.valid & bus.wstrb;
    assign rd_en        = bus.valid & ~bus.wstrb;
    assign locked       = (state == S_LOCKED);
    assign busy         = (state != S_OFF) && !locked;
    assign step_due     = (div_cnt == 16'd0);
    assign unused_wdata = ^bus.wdata[DATA_W-1:16];

    // Read view of the register file as seen before the sampling edge.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_CTRL:   rd_mux[0]     = en;
            A_TARGET: rd_mux[7:0]   = target;
            A_STEP:   rd_mux[15:0]  = step_div;
            A_SETTLE: rd_mux[15:0]  = settle;
            A_STATUS: begin
                rd_mux[0]    = busy;
                rd_mux[1]    = locked;
                rd_mux[4:2]  = state;
                rd_mux[15:8] = charge;
            end
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en        <= 1'b0;
            target    <= 8'd0;
            step_div  <= 16'd0;
            settle    <= 16'd0;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= bus.valid;
            bus.rdata <= rd_en ? rd_mux : '0;
            if (wr_en) begin
                case (bus.address)
                    A_CTRL:   en       <= bus.wdata[0];
                    A_TARGET: target   <= bus.wdata[7:0];
                    A_STEP:   step_div <= bus.wdata[15:0];
                    A_SETTLE: settle   <= bus.wdata[15:0];
                    default:  ;
                endcase
            end
        end
    end

    // Sequencer: pd and charge are registered here, never decoded from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OFF;
            pd         <= 1'b1;
            charge     <= 8'd0;
            settle_cnt <= 16'd0;
            div_cnt    <= 16'd0;
        end else begin
            case (state)
                S_OFF: begin
                    pd     <= 1'b1;
                    charge <= 8'd0;
                    if (en) begin
                        state      <= S_SETTLE;
                        pd         <= 1'b0;
                        settle_cnt <= settle;
                    end
                end
                S_SETTLE: begin
                    if (!en) begin
                        state <= S_OFF;
                        pd    <= 1'b1;
                    end else if (settle_cnt == 16'd0) begin
                        state   <= S_RAMP;
                        div_cnt <= step_div;
                    end else begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                S_RAMP: begin
                    if (!en) begin
                        state   <= S_RAMPDN;
                        div_cnt <= step_div;
                    end else if (charge == target) begin
                        state <= S_LOCKED;
                    end else if (step_due) begin
                        // Direction is re-decided at every step boundary from the live target.
                        div_cnt <= step_div;
                        if (charge < target) begin
                            charge <= (charge == 8'hFF) ? charge : charge + 8'd1;
                        end else begin
                            charge <= (charge == 8'h00) ? charge : charge - 8'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                S_LOCKED: begin
                    if (!en) begin
                        state   <= S_RAMPDN;
                        div_cnt <= step_div;
                    end else if (target != charge) begin
                        state   <= S_RAMP;
                        div_cnt <= step_div;
                    end
                end
                S_RAMPDN: begin
                    if (en) begin
                        state   <= S_RAMP;
                        div_cnt <= step_div;
                    end else if (charge == 8'd0) begin
                        state <= S_OFF;
                        pd    <= 1'b1;
                    end else if (step_due) begin
                        div_cnt <= step_div;
                        charge  <= charge - 8'd1;
                        if (charge == 8'd1) begin
                            state <= S_OFF;
                            pd    <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    pd     <= 1'b1;
                    charge <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iref_seq.sv
// Directed bench for iref_seq: spec-level cycle model checked every cycle plus literal checkpoints.
module tb_iref_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       pd;
    logic [7:0] charge;

    iref_seq_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    iref_seq #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pd     (pd),
        .charge (charge)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phases as plain ints, waits counted up against a period latched at each boundary.
    localparam int M_OFF = 0, M_SETTLE = 1, M_RAMP = 2, M_LOCKED = 3, M_RAMPDN = 4;
    int          m_state, m_charge, m_elapsed, m_period;
    int          m_target, m_step, m_settle;
    bit          m_en, m_pd, m_ready;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(input int a);
        int busy;
        busy = (m_state != M_OFF && m_state != M_LOCKED) ? 1 : 0;
        case (a)
            0: return 32'(m_en);
            1: return 32'(m_target);
            2: return 32'(m_step);
            3: return 32'(m_settle);
            4: return 32'(busy + 2 * (m_state == M_LOCKED ? 1 : 0) + 4 * m_state + 256 * m_charge);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void enter_stepping(input int st);
        m_state   = st;
        m_elapsed = 0;
        m_period  = m_step;
    endfunction

    function automatic void model_advance();
        case (m_state)
            M_OFF: if (m_en) begin
                m_state = M_SETTLE; m_pd = 0; m_elapsed = 0; m_period = m_settle;
            end
            M_SETTLE: begin
                if (!m_en) begin m_state = M_OFF; m_pd = 1; end
                else if (m_elapsed == m_period) enter_stepping(M_RAMP);
                else m_elapsed++;
            end
            M_RAMP: begin
                if (!m_en) enter_stepping(M_RAMPDN);
                else if (m_charge == m_target) m_state = M_LOCKED;
                else if (m_elapsed == m_period) begin
                    m_charge += (m_target > m_charge) ? 1 : -1;
                    if (m_charge > 255) m_charge = 255;
                    if (m_charge < 0) m_charge = 0;
                    m_elapsed = 0; m_period = m_step;
                end else m_elapsed++;
            end
            M_LOCKED: begin
                if (!m_en) enter_stepping(M_RAMPDN);
                else if (m_target != m_charge) enter_stepping(M_RAMP);
            end
            M_RAMPDN: begin
                if (m_en) enter_stepping(M_RAMP);
                else if (m_charge == 0) begin m_state = M_OFF; m_pd = 1; end
                else if (m_elapsed == m_period) begin
                    m_charge--; m_elapsed = 0; m_period = m_step;
                    if (m_charge == 0) begin m_state = M_OFF; m_pd = 1; end
                end else m_elapsed++;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_OFF; m_charge = 0; m_elapsed = 0; m_period = 0;
            m_target = 0; m_step = 0; m_settle = 0;
            m_en = 0; m_pd = 1; m_ready = 0; m_rdata = 32'd0;
        end else begin
            m_ready = bus.valid;
            m_rdata = (bus.valid && !bus.wstrb) ? model_read(int'(bus.address)) : 32'd0;
            model_advance();
            if (bus.valid && bus.wstrb) begin
                case (bus.address)
                    3'd0: m_en     = bus.wdata[0];
                    3'd1: m_target = int'(bus.wdata[7:0]);
                    3'd2: m_step   = int'(bus.wdata[15:0]);
                    3'd3: m_settle = int'(bus.wdata[15:0]);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_pd", 32'(pd), 32'(m_pd));
            check("model_charge", 32'(charge), 32'(m_charge));
            check("model_ready", 32'(bus.ready), 32'(m_ready));
            if (m_ready) check("model_rdata", bus.rdata, m_rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.valid = 1'b1; bus.wstrb = 1'b1; bus.address = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.valid = 1'b0; bus.wstrb = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic r);
        bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = a;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        d = bus.rdata;
        r = bus.ready;
    endtask

    int exp1_charge [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
    int exp2_charge [6]  = '{4, 4, 3, 2, 2, 2};
    int exp3_charge [5]  = '{2, 2, 1, 0, 0};
    int exp3_pd     [5]  = '{0, 0, 0, 1, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        r;
        int          n;

        bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = 3'd0; bus.wdata = 32'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        tick(2);
        check("reset_pd", 32'(pd), 32'd1);
        check("reset_charge", 32'(charge), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        // Settle 3, divide by 2, ramp to 4.
        wr(3'd3, 32'd3);
        wr(3'd2, 32'd1);
        wr(3'd1, 32'd4);
        wr(3'd0, 32'd1);
        check("pd_at_en_write", 32'(pd), 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("ramp_up_pd", 32'(pd), 32'd0);
            check("ramp_up_charge", 32'(charge), 32'(exp1_charge[i]));
        end
        rd(3'd4, d, r);
        check("status_locked_4", d, 32'h0000_040E);

        // Retarget down to 2 at one step per cycle.
        wr(3'd2, 32'd0);
        wr(3'd1, 32'd2);
        check("retarget_charge", 32'(charge), 32'(exp2_charge[0]));
        for (int i = 1; i < 6; i++) begin
            tick(1);
            check("retarget_charge", 32'(charge), 32'(exp2_charge[i]));
        end
        rd(3'd4, d, r);
        check("status_locked_2", d, 32'h0000_020E);

        // Disable from LOCKED: ramp down to 0 then power down.
        wr(3'd0, 32'd0);
        check("rampdn_charge", 32'(charge), 32'(exp3_charge[0]));
        check("rampdn_pd", 32'(pd), 32'(exp3_pd[0]));
        for (int i = 1; i < 5; i++) begin
            tick(1);
            check("rampdn_charge", 32'(charge), 32'(exp3_charge[i]));
            check("rampdn_pd", 32'(pd), 32'(exp3_pd[i]));
        end
        rd(3'd4, d, r);
        check("status_off", d, 32'h0000_0000);

        // Abort during SETTLE.
        wr(3'd3, 32'd10);
        wr(3'd0, 32'd1);
        tick(2);
        check("settle_pd", 32'(pd), 32'd0);
        rd(3'd4, d, r);
        check("status_settle", d, 32'h0000_0005);
        wr(3'd0, 32'd0);
        check("abort_pd_before", 32'(pd), 32'd0);
        tick(1);
        check("abort_pd_after", 32'(pd), 32'd1);
        check("abort_charge", 32'(charge), 32'd0);
        rd(3'd4, d, r);
        check("status_after_abort", d, 32'h0000_0000);

        // Full-scale ramp to 255 with no wrap.
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd255);
        wr(3'd0, 32'd1);
        n = 0;
        while (charge != 8'd255 && n < 400) begin
            tick(1);
            n++;
        end
        check("cycles_to_255", 32'(n), 32'd257);
        tick(20);
        check("hold_255_charge", 32'(charge), 32'd255);
        check("hold_255_pd", 32'(pd), 32'd0);
        rd(3'd4, d, r);
        check("status_locked_255", d, 32'h0000_FF0E);

        // Ramp down toward 50, reset at 100 with a colliding write.
        wr(3'd1, 32'd50);
        n = 0;
        while (charge != 8'd100 && n < 400) begin
            tick(1);
            n++;
        end
        check("reached_100", 32'(charge), 32'd100);
        rst = 1'b1;
        bus.valid = 1'b1; bus.wstrb = 1'b1; bus.address = 3'd1; bus.wdata = 32'h77;
        tick(1);
        rst = 1'b0;
        bus.valid = 1'b0; bus.wstrb = 1'b0;
        check("midramp_rst_pd", 32'(pd), 32'd1);
        check("midramp_rst_charge", 32'(charge), 32'd0);
        check("midramp_rst_ready", 32'(bus.ready), 32'd0);
        check("midramp_rst_rdata", bus.rdata, 32'd0);
        for (int a = 0; a < 5; a++) begin
            rd(3'(a), d, r);
            check("post_rst_reg", d, 32'd0);
        end
        rd(3'd6, d, r);
        check("addr6_ready", 32'(r), 32'd1);
        check("addr6_rdata", d, 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iref_seq.md
IREF_SEQ -- requirements
Module: iref_seq

Interface
REQ-001 The parameter list SHALL include: DATA_W, 32, CPU data width.
REQ-002 The parameter list SHALL include: ADDR_W, 3, CPU word-address width.
REQ-003 The ports SHALL be: clk  input  1  system clock, single clock domain.
REQ-004 The ports SHALL include: rst  input  1  reset; synchronous and active-high.
REQ-005 The ports SHALL include: valid  input  1  CPU request strobe.
REQ-006 The ports SHALL include: address  input  ADDR_W  register select.
REQ-007 The ports SHALL include: wdata  input  DATA_W  write data.
REQ-008 The ports SHALL include: wstrb  input  1  1=write, 0=read.
REQ-009 The ports SHALL include: rdata  output  DATA_W  read data, valid while ready=1.
REQ-010 The ports SHALL include: ready  output  1  one-cycle acknowledge.
REQ-011 The ports SHALL include: pd  output  1  current-reference power-down, 1=off.
REQ-012 The ports SHALL include: charge  output  8  current-reference charge code.

Function
REQ-013 Register map (word address): 0 CTRL bit0=en; 1 TARGET bits7:0; 2 STEP_DIV bits15:0; 3 SETTLE bits15:0; 4 STATUS read-only.
REQ-014 STATUS SHALL read as follows: bit0=busy (state not OFF and not LOCKED); bit1=locked; bits4:2=state code; bits15:8=charge; all other bits 0.
REQ-015 Every cycle with valid=1 SHALL produce ready=1 on the next cycle; ready SHALL be 0 otherwise; back-to-back requests SHALL be acknowledged every cycle.
REQ-016 Writes SHALL take effect on the clock edge that samples valid=1, wstrb=1; writes to address 4 or to addresses 5-7 SHALL be ignored but acknowledged.
REQ-017 Reads SHALL return the register value at the edge sampling the request; addresses 5-7 SHALL read 0.
REQ-018 The FSM states SHALL be: OFF=0, SETTLE=1, RAMP=2, LOCKED=3, RAMPDN=4.
REQ-019 In OFF: pd=1, charge=0; when en=1, the FSM SHALL go to SETTLE, pd=0, and the settle counter SHALL load SETTLE.
REQ-020 In SETTLE: the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RAMP (SETTLE=0 gives exactly one SETTLE cycle); en=0 SHALL return the FSM to OFF next cycle with pd=1.
REQ-021 In RAMP: the step divider SHALL count STEP_DIV+1 cycles per step; each step SHALL move charge by exactly 1 toward TARGET, with direction re-evaluated every step.
REQ-022 In RAMP, when charge==TARGET the FSM SHALL go to LOCKED (checked before stepping, so no overshoot); if en=0 the FSM SHALL go to RAMPDN.
REQ-023 In LOCKED: if TARGET!=charge the FSM SHALL go to RAMP with the divider reloaded; if en=0 it SHALL go to RAMPDN.
REQ-024 In RAMPDN: charge SHALL decrement 1 per STEP_DIV+1 cycles; at charge==0 the FSM SHALL go to OFF and assert pd=1 on the same edge; en=1 SHALL return the FSM to RAMP with pd held 0.
REQ-025 The charge code SHALL never wrap: it SHALL saturate at 0 and 255 and never pass TARGET.
REQ-026 A STEP_DIV or TARGET write during RAMP SHALL take effect at the next step boundary; the divider SHALL NOT restart.
REQ-027 pd and charge SHALL be registered outputs with no combinational path from CPU inputs.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set: state=OFF, pd=1, charge=0, ready=0, rdata=0, en=0, TARGET=0, STEP_DIV=0, SETTLE=0, all counters 0.
REQ-029 Reset mid-ramp SHALL drop charge to 0 and set pd=1 on that edge, with no ramp-down.
REQ-030 Reset SHALL override any simultaneous CPU write.

Verification
REQ-031 The bench SHALL cover: SETTLE=3, STEP_DIV=1, TARGET=4, en=1 -> pd falls 1 cycle after the en write; 4 SETTLE cycles; charge 1,2,3,4 every 2 cycles; STATUS=0x040E (locked, state 3).
REQ-032 The bench SHALL cover: in LOCKED at 4, TARGET=2 -> charge 3 then 2 at 1-cycle-per-step spacing with STEP_DIV=0, returns to LOCKED, no overshoot.
REQ-033 The bench SHALL cover: en=0 from LOCKED at 2 with STEP_DIV=0 -> charge 1, 0; pd=1 on the edge charge reaches 0; state OFF.
REQ-034 The bench SHALL cover: en=0 during SETTLE -> OFF next cycle, pd=1, charge stays 0.
REQ-035 The bench SHALL cover: TARGET=255, STEP_DIV=0 -> charge reaches 255 and holds, with no wrap to 0.
REQ-036 The bench SHALL cover: rst=1 while charge=100 in RAMP -> next edge pd=1, charge=0, all registers 0; read of address 6 -> ready=1, rdata=0.
